dram_bus_if: RTL and testbench
==============================

Name: dram_bus_if

Overview:
68040 bus-side front end for the DRAM controller; sits directly upstream of the DRAM controller state machine.
- Decodes 68040 transfer starts that hit the DRAM window and latches the address and attributes.
- Presents row, column and byte lanes to the controller and sequences 68040 line bursts (4 beats, wrapping).
- Returns nTA per beat, and nTEA when the controller never answers (e.g. still in init or refresh deadlock).

Parameters:
DRAM_BASE, 32'h0000_0000, base address of the DRAM window
DRAM_MASK, 32'hFF00_0000, address bits compared against DRAM_BASE (16 MB window)
ROW_BITS, 12, row address width (4096 rows, matches refresh count)
COL_BITS, 10, column address width (longword columns)
TIMEOUT, 1023, cycles without controller progress before bus error

Ports:
clk  in  1  system clock, 33 MHz; all logic on rising edge
RESET  in  1  synchronous, active-high reset
nTS  in  1  68040 transfer start, active low
A  in  32  68040 address
RnW  in  1  1 = read, 0 = write
SIZ  in  2  00 long, 01 byte, 10 word, 11 line
TT  in  2  transfer type; only 00 (normal) is decoded
nTA  out  1  transfer acknowledge, active low
nTEA  out  1  transfer error acknowledge, active low
dram_req  out  1  access request to the controller
dram_we  out  1  write access
dram_row  out  ROW_BITS  row address, A[23:12]
dram_col  out  COL_BITS  column address, A[11:2]; bits [1:0] advance during a burst
dram_ben  out  4  byte lane enables; [3] = D31:24
dram_burst  out  1  more beats follow the current one
dram_gnt  in  1  controller accepted the request (row open); one-cycle pulse
dram_beat  in  1  current column cycle complete; one-cycle pulse
busy  out  1  block is not in IDLE

Behaviour:
- Reset values: nTA=1, nTEA=1, dram_req=0, dram_we=0, dram_row=0, dram_col=0, dram_ben=0, dram_burst=0, busy=0, state=IDLE.
- Hit condition: nTS==0 && TT==00 && (A & DRAM_MASK)==DRAM_BASE, sampled in IDLE.
  - Non-hits are ignored; another decoder owns them.
  - nTS is ignored in every state except IDLE.
- On a hit, latch in the same cycle:
  - row and column from A.
  - dram_we = ~RnW.
  - beats_left = 4 for a line transfer, else 1.
  - dram_ben:
    - byte: one-hot at bit 3-A[1:0].
    - word: 1100 if A[1]==0, else 0011.
    - long or line: 1111.
- State machine:
  - IDLE -> REQ on a hit.
  - REQ: dram_req=1; row, col, ben and we held stable. dram_gnt -> BEAT.
  - BEAT: dram_req stays 1. On each dram_beat:
    - Drive nTA=0 in the following cycle only (exactly 1 cycle wide).
    - If beats_left > 1: decrement beats_left; dram_col[1:0] += 1 mod 4, so a burst starting at col[1:0]=2 runs 2,3,0,1; dram_col[COL_BITS-1:2] never changes. Stay in BEAT.
    - If beats_left == 1: drop dram_req in the next cycle and return to IDLE.
- dram_burst = 1 while beats_left > 1.
- busy = (state != IDLE).
- Watchdog: counter cleared on entry to REQ and on every dram_gnt or dram_beat, and increments otherwise in REQ/BEAT.
  - When the count reaches TIMEOUT: nTEA=0 for one cycle, dram_req=0, go to IDLE, and no nTA is issued in that cycle.
  - If dram_beat and the timeout occur in the same cycle, the beat wins and the counter clears.
- dram_gnt seen in BEAT, or dram_beat seen in REQ: ignored.
- nTA and nTEA are never low in the same cycle.
- RESET asserted mid-transfer: all outputs return to their reset values on the next edge; no nTA or nTEA is issued for the aborted transfer.

Decomposition:
- Shared package dram_pkg:
  - SIZ encodings: SIZ_LONG, SIZ_BYTE, SIZ_WORD, SIZ_LINE.
  - TT_NORMAL.
  - ROW_BITS and COL_BITS defaults.
  - State encoding: IDLE, REQ, BEAT.
- One natural sub-module: dram_ben_dec, a combinational SIZ/A[1:0] to byte-enable decoder, reused by the write-data path.

Test Plan:
- Long read at A=0x0012_3458, nTS low 1 cycle -> dram_row=0x123, dram_col=0x116, ben=1111, we=0; gnt, then beat -> one nTA pulse 1 cycle after beat; busy returns to 0.
- Line write at A=0x0000_0008 -> dram_col[1:0] sequence 2,3,0,1; 4 nTA pulses; dram_burst=1 for the first 3 beats, 0 on the last; we=1.
- Byte write at A[1:0]=01 -> ben=0100; word at A[1]=1 -> ben=0011.
- Miss: A=0x0100_0000 with nTS low, and a hit with TT=01 -> dram_req stays 0, busy stays 0.
- No gnt for TIMEOUT cycles -> exactly one nTEA pulse, dram_req drops, no nTA; a beat landing on the timeout cycle instead gives nTA and no nTEA.
- RESET pulsed during beat 2 of a line -> next cycle dram_req=0, nTA=1, nTEA=1, busy=0; a fresh nTS afterwards is accepted normally.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the 68040 DRAM bus front end.
// Holds the SIZ/TT encodings, the default row/column widths and the
// front-end state encoding used by dram_bus_if and its bench.
package dram_pkg;

    // 68040 SIZ encodings
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    // Only normal accesses are decoded; other transfer types belong elsewhere.
    localparam logic [1:0] TT_NORMAL = 2'b00;

    // Default DRAM geometry: 4096 rows, 1024 longword columns.
    localparam int ROW_BITS_DEF = 12;
    localparam int COL_BITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BEAT = 2'd2
    } state_e;

endpackage

// File: rtl/dram_bus_if_if.sv
// Controller-side handshake between the 68040 front end and the DRAM
// controller state machine.
//   master (front end): drives dram_req/we/row/col/ben/burst,
//                       receives dram_gnt/dram_beat.
//   slave  (controller): the reverse.
// Handshake: dram_req is held high with row/col/ben/we stable until the
// controller pulses dram_gnt for one cycle (row open). Each following
// one-cycle dram_beat pulse completes the current column; dram_col and
// dram_burst then describe the next beat. dram_req drops after the last beat.
interface dram_bus_if_if #(
    parameter int ROW_BITS = dram_pkg::ROW_BITS_DEF,
    parameter int COL_BITS = dram_pkg::COL_BITS_DEF
);
    logic                dram_req;
    logic                dram_we;
    logic [ROW_BITS-1:0] dram_row;
    logic [COL_BITS-1:0] dram_col;
    logic [3:0]          dram_ben;
    logic                dram_burst;
    logic                dram_gnt;
    logic                dram_beat;

    modport master (
        output dram_req, dram_we, dram_row, dram_col, dram_ben, dram_burst,
        input  dram_gnt, dram_beat
    );

    modport slave (
        input  dram_req, dram_we, dram_row, dram_col, dram_ben, dram_burst,
        output dram_gnt, dram_beat
    );
endinterface

// File: rtl/dram_ben_dec.sv
// Combinational 68040 SIZ / A[1:0] to byte-lane decoder.
// Ports: siz_i (SIZ), a_lo_i (A[1:0]), ben_o (lane enables, [3] = D31:24).
// Big-endian lanes: byte address 0 lives on D31:24.
module dram_ben_dec
    import dram_pkg::*;
(
    input  logic [1:0] siz_i,
    input  logic [1:0] a_lo_i,
    output logic [3:0] ben_o
);
    always_comb begin
        ben_o = 4'b1111;
        case (siz_i)
            SIZ_BYTE: ben_o = 4'b1000 >> a_lo_i;
            SIZ_WORD: ben_o = a_lo_i[1] ? 4'b0011 : 4'b1100;
            default:  ben_o = 4'b1111;
        endcase
    end
endmodule

// File: rtl/dram_bus_if.sv
// 68040 bus-side front end for the DRAM controller.
// Decodes transfer starts in the DRAM window, latches address/attributes,
// presents row/col/byte lanes to the controller, sequences 4-beat wrapping
// line bursts, returns nTA per beat and nTEA when the controller stalls.
// Ports:
//   clk, RESET        clock, synchronous active-high reset
//   nTS, A, RnW, SIZ, TT   68040 transfer start and attributes
//   nTA, nTEA         transfer / error acknowledge (active low, 1 cycle)
//   busy              high whenever the FSM is not IDLE
//   dbg_state         current FSM state
//   dram              controller handshake (master side)
module dram_bus_if
    import dram_pkg::*;
#(
    parameter logic [31:0] DRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] DRAM_MASK = 32'hFF00_0000,
    parameter int          ROW_BITS  = ROW_BITS_DEF,
    parameter int          COL_BITS  = COL_BITS_DEF,
    parameter int          TIMEOUT   = 1023
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          nTS,
    input  logic [31:0]   A,
    input  logic          RnW,
    input  logic [1:0]    SIZ,
    input  logic [1:0]    TT,
    output logic          nTA,
    output logic          nTEA,
    output logic          busy,
    output state_e        dbg_state,
    dram_bus_if_if.master dram
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [3:0]          ben_q, ben_d;
    logic                we_q, we_d;
    logic [2:0]          beats_q, beats_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                nta_q, nta_d;
    logic                ntea_q, ntea_d;

    logic       hit;
    logic       progress;
    logic       wd_expire;
    logic [3:0] ben_dec;

    dram_ben_dec u_ben_dec (
        .siz_i  (SIZ),
        .a_lo_i (A[1:0]),
        .ben_o  (ben_dec)
    );

    assign hit = !nTS && (TT == TT_NORMAL) && ((A & DRAM_MASK) == DRAM_BASE);

    // Only a grant in REQ or a beat in BEAT counts as controller progress;
    // the out-of-phase pulse is ignored and does not feed the watchdog.
    assign progress = ((state_q == REQ) && dram.dram_gnt) ||
                      ((state_q == BEAT) && dram.dram_beat);

    // Fires on the cycle the stall count would reach TIMEOUT. A beat in the
    // same cycle counts as progress, so the beat wins.
    assign wd_expire = (state_q != IDLE) && !progress &&
                       (wd_q == WD_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hit) state_d = REQ;
            REQ: begin
                if (dram.dram_gnt)  state_d = BEAT;
                else if (wd_expire) state_d = IDLE;
            end
            BEAT: begin
                if (dram.dram_beat) begin
                    if (beats_q == 3'd1) state_d = IDLE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: address latch, burst sequencing, watchdog, acks
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        ben_d   = ben_q;
        we_d    = we_q;
        beats_d = beats_q;
        wd_d    = wd_q;
        nta_d   = 1'b1;
        ntea_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    row_d   = A[ROW_BITS+COL_BITS+1 -: ROW_BITS];
                    col_d   = A[COL_BITS+1:2];
                    ben_d   = ben_dec;
                    we_d    = ~RnW;
                    beats_d = (SIZ == SIZ_LINE) ? 3'd4 : 3'd1;
                    wd_d    = '0;
                end
            end
            REQ: begin
                wd_d = (dram.dram_gnt || wd_expire) ? '0 : wd_q + 1'b1;
            end
            BEAT: begin
                if (dram.dram_beat) begin
                    wd_d  = '0;
                    nta_d = 1'b0;
                    if (beats_q > 3'd1) begin
                        beats_d    = beats_q - 3'd1;
                        // Wrap within the 4-longword line; upper column bits stay put.
                        col_d[1:0] = col_q[1:0] + 2'd1;
                    end
                end else begin
                    wd_d = wd_expire ? '0 : wd_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (wd_expire) ntea_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            row_q   <= '0;
            col_q   <= '0;
            ben_q   <= '0;
            we_q    <= 1'b0;
            beats_q <= '0;
            wd_q    <= '0;
            nta_q   <= 1'b1;
            ntea_q  <= 1'b1;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            ben_q   <= ben_d;
            we_q    <= we_d;
            beats_q <= beats_d;
            wd_q    <= wd_d;
            nta_q   <= nta_d;
            ntea_q  <= ntea_d;
        end
    end

    // Outputs
    always_comb begin
        busy            = (state_q != IDLE);
        dram.dram_req   = (state_q != IDLE);
        dram.dram_burst = (state_q != IDLE) && (beats_q > 3'd1);
        dram.dram_we    = we_q;
        dram.dram_row   = row_q;
        dram.dram_col   = col_q;
        dram.dram_ben   = ben_q;
        nTA             = nta_q;
        nTEA            = ntea_q;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_dram_bus_if.sv
// Self-checking bench for dram_bus_if: a driver issues 68040 transfers and
// controller pulses, pushing the expected acknowledge for each beat (or
// timeout) into a queue; a monitor pops and compares on every nTA/nTEA.
module tb_dram_bus_if;
    import dram_pkg::*;

    localparam int TIMEOUT = 1023;

    typedef struct packed {
        logic        tea;
        logic [11:0] row;
        logic [9:0]  col;
        logic [3:0]  ben;
        logic        we;
        logic        burst;
    } ev_t;

    logic        clk = 1'b0;
    logic        RESET;
    logic        nTS;
    logic [31:0] A;
    logic        RnW;
    logic [1:0]  SIZ;
    logic [1:0]  TT;
    logic        nTA;
    logic        nTEA;
    logic        busy;
    state_e      dbg_state;

    dram_bus_if_if bus ();

    dram_bus_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .nTS       (nTS),
        .A         (A),
        .RnW       (RnW),
        .SIZ       (SIZ),
        .TT        (TT),
        .nTA       (nTA),
        .nTEA      (nTEA),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dram      (bus)
    );

    // Clock / global bound
    always #15 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL global_timeout: simulation did not finish, required finish before 20ms");
        $fatal(1, "global timeout");
    end

    // Scoreboard state
    logic [28:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    ev_t prev_snap;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Reference byte-lane rule: byte -> one-hot at 3-A[1:0]; word -> by A[1]; else all.
    function automatic logic [3:0] ben_model(input logic [1:0] siz, input logic [1:0] lo);
        int sh;
        case (siz)
            SIZ_BYTE: begin
                sh = 3 - int'(lo);
                return 4'(1 << sh);
            end
            SIZ_WORD: return lo[1] ? 4'b0011 : 4'b1100;
            default:  return 4'b1111;
        endcase
    endfunction

    // Monitor: acks reflect the beat presented in the previous cycle.
    always @(negedge clk) begin
        ev_t got;
        ev_t exp;
        if (RESET !== 1'b1) begin
            if (nTA === 1'b0 && nTEA === 1'b0) begin
                checks++;
                errors++;
                $display("FAIL ack_exclusive: nTA=%b nTEA=%b required not both low", nTA, nTEA);
            end else if (nTA === 1'b0 || nTEA === 1'b0) begin
                got = prev_snap;
                got.tea = (nTEA === 1'b0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: got %h required no acknowledge", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL ack_event: got %h required %h", got, exp);
                    end
                end
            end
        end
        prev_snap.tea   = 1'b0;
        prev_snap.row   = bus.dram_row;
        prev_snap.col   = bus.dram_col;
        prev_snap.ben   = bus.dram_ben;
        prev_snap.we    = bus.dram_we;
        prev_snap.burst = bus.dram_burst;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic rnw, input logic [1:0] siz,
                         input logic [1:0] tt);
        nTS = 1'b0;
        A   = a;
        RnW = rnw;
        SIZ = siz;
        TT  = tt;
        tick();
        nTS = 1'b1;
        TT  = TT_NORMAL;
    endtask

    function automatic ev_t model_ev(input logic [31:0] a, input logic rnw, input logic [1:0] siz,
                                     input int beat_idx, input logic tea);
        ev_t e;
        int  nb;
        logic [1:0] lo;
        nb      = (siz == SIZ_LINE) ? 4 : 1;
        lo      = 2'((int'(a[3:2]) + beat_idx) % 4);
        e.tea   = tea;
        e.row   = a[23:12];
        e.col   = {a[11:4], lo};
        e.ben   = ben_model(siz, a[1:0]);
        e.we    = ~rnw;
        e.burst = (nb - beat_idx) > 1;
        return e;
    endfunction

    // Full transfer; the address is assumed to hit the window.
    task automatic run_xfer(input logic [31:0] a, input logic rnw, input logic [1:0] siz,
                            input int gnt_dly, input int gap);
        int nb;
        ev_t e;
        nb = (siz == SIZ_LINE) ? 4 : 1;
        issue(a, rnw, siz, TT_NORMAL);
        e = model_ev(a, rnw, siz, 0, 1'b0);
        check("req_up",  32'(bus.dram_req), 32'd1);
        check("busy_up", 32'(busy), 32'd1);
        check("req_row", 32'(bus.dram_row), 32'(e.row));
        check("req_col", 32'(bus.dram_col), 32'(e.col));
        check("req_ben", 32'(bus.dram_ben), 32'(e.ben));
        check("req_we",  32'(bus.dram_we), 32'(e.we));
        repeat (gnt_dly) tick();
        bus.dram_gnt = 1'b1;
        tick();
        bus.dram_gnt = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat (gap) tick();
            exp_q.push_back(model_ev(a, rnw, siz, i, 1'b0));
            bus.dram_beat = 1'b1;
            tick();
            bus.dram_beat = 1'b0;
        end
        tick();
        check("busy_done", 32'(busy), 32'd0);
        check("req_done",  32'(bus.dram_req), 32'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_req"},  32'(bus.dram_req), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  siz;
        logic        rnw;
        RESET = 1'b1;
        nTS = 1'b1;
        A = '0;
        RnW = 1'b1;
        SIZ = SIZ_LONG;
        TT = TT_NORMAL;
        bus.dram_gnt = 1'b0;
        bus.dram_beat = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_nTA",   32'(nTA), 32'd1);
        check("rst_nTEA",  32'(nTEA), 32'd1);
        check("rst_req",   32'(bus.dram_req), 32'd0);
        check("rst_we",    32'(bus.dram_we), 32'd0);
        check("rst_row",   32'(bus.dram_row), 32'd0);
        check("rst_col",   32'(bus.dram_col), 32'd0);
        check("rst_ben",   32'(bus.dram_ben), 32'd0);
        check("rst_burst", 32'(bus.dram_burst), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        RESET = 1'b0;
        tick();

        // Directed: long read, line write, byte and word writes
        issue(32'h0012_3458, 1'b1, SIZ_LONG, TT_NORMAL);
        check("lr_row", 32'(bus.dram_row), 32'h123);
        check("lr_col", 32'(bus.dram_col), 32'h116);
        check("lr_ben", 32'(bus.dram_ben), 32'hF);
        check("lr_we",  32'(bus.dram_we), 32'd0);
        bus.dram_gnt = 1'b1;
        tick();
        bus.dram_gnt = 1'b0;
        exp_q.push_back(ev_t'{1'b0, 12'h123, 10'h116, 4'hF, 1'b0, 1'b0});
        bus.dram_beat = 1'b1;
        tick();
        bus.dram_beat = 1'b0;
        check("lr_nTA_pulse", 32'(nTA), 32'd0);
        tick();
        check("lr_nTA_width", 32'(nTA), 32'd1);
        check("lr_busy", 32'(busy), 32'd0);

        run_xfer(32'h0000_0008, 1'b0, SIZ_LINE, 1, 1);
        run_xfer(32'h0000_1001, 1'b0, SIZ_BYTE, 0, 0);
        run_xfer(32'h0000_2002, 1'b0, SIZ_WORD, 2, 2);
        run_xfer(32'h00FF_FFFC, 1'b1, SIZ_LINE, 0, 0);

        // Misses: outside window, and non-normal TT
        issue(32'h0100_0000, 1'b1, SIZ_LONG, TT_NORMAL);
        check_idle("miss_addr");
        tick();
        check_idle("miss_addr2");
        issue(32'h0000_4000, 1'b1, SIZ_LONG, 2'b01);
        check_idle("miss_tt");
        tick();
        check_idle("miss_tt2");

        // Controller never grants: one nTEA after TIMEOUT stalled cycles
        issue(32'h0034_5670, 1'b1, SIZ_LONG, TT_NORMAL);
        exp_q.push_back(model_ev(32'h0034_5670, 1'b1, SIZ_LONG, 0, 1'b1));
        k = 0;
        while (nTEA !== 1'b0 && k < TIMEOUT + 5) begin
            tick();
            k++;
        end
        check("tea_latency", 32'(k), 32'(TIMEOUT));
        check("tea_req_drop", 32'(bus.dram_req), 32'd0);
        tick();
        check("tea_width", 32'(nTEA), 32'd1);
        check_idle("tea_idle");

        // Beat landing on the timeout cycle wins
        issue(32'h0000_0100, 1'b1, SIZ_LONG, TT_NORMAL);
        bus.dram_gnt = 1'b1;
        tick();
        bus.dram_gnt = 1'b0;
        repeat (TIMEOUT - 1) tick();
        exp_q.push_back(model_ev(32'h0000_0100, 1'b1, SIZ_LONG, 0, 1'b0));
        bus.dram_beat = 1'b1;
        tick();
        bus.dram_beat = 1'b0;
        repeat (3) tick();
        check_idle("race_idle");

        // Reset during beat 2 of a line
        issue(32'h0000_0010, 1'b1, SIZ_LINE, TT_NORMAL);
        bus.dram_gnt = 1'b1;
        tick();
        bus.dram_gnt = 1'b0;
        exp_q.push_back(model_ev(32'h0000_0010, 1'b1, SIZ_LINE, 0, 1'b0));
        bus.dram_beat = 1'b1;
        tick();
        bus.dram_beat = 1'b0;
        repeat (2) tick();
        RESET = 1'b1;
        bus.dram_beat = 1'b1;
        tick();
        RESET = 1'b0;
        bus.dram_beat = 1'b0;
        check("rstmid_req",  32'(bus.dram_req), 32'd0);
        check("rstmid_nTA",  32'(nTA), 32'd1);
        check("rstmid_nTEA", 32'(nTEA), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        tick();
        run_xfer(32'h0000_0040, 1'b0, SIZ_LONG, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            a = {8'h00, r[23:0]};
            siz = 2'($urandom_range(0, 3));
            rnw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a[24 + $urandom_range(0, 7)] = 1'b1;
                issue(a, rnw, siz, TT_NORMAL);
                check_idle("rnd_miss");
            end else begin
                run_xfer(a, rnw, siz, $urandom_range(0, 4), $urandom_range(0, 3));
            end
        end

        repeat (4) tick();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
